// File: rtl/rfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package rfile_pkg;

  typedef enum logic [1:0] {WS_B, WS_H, WS_W, WS_D} wsize_t;

  typedef enum logic {INIT, RUN} rf_state_t;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic int size_bytes(wsize_t s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/rfile_wmask.sv
// Per-write-port lane placement: byte enables, lane-aligned data, illegal flag.
module rfile_wmask
  import rfile_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]        size,
  input  logic [2:0]        pos,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic              illegal
);

  localparam int NB = XLEN / 8;

  int sb;
  int off;

  // Place the low sb bytes of data at byte offset pos*sb; a double ignores pos.
  always_comb begin
    sb      = size_bytes(wsize_t'(size));
    off     = (wsize_t'(size) == WS_D) ? 0 : int'(pos) * sb;
    illegal = (sb > NB) || (off + sb > NB);
    be      = '0;
    wdata   = '0;
    for (int b = 0; b < NB; b++) begin
      if (!illegal && b >= off && b < off + sb) begin
        be[b]           = 1'b1;
        wdata[b*8 +: 8] = data[(b-off)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rfile_mp.sv
// Multi-port integer register file with byte-merged write conflicts,
// optional write-to-read bypass, hardwired r0 and a post-reset clear sweep.
module rfile_mp
  import rfile_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int XN      = 64,
  parameter int XWDT    = $clog2(XN),
  parameter int NREAD   = 3,
  parameter int NWRITE  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         ready,
  input  logic [NREAD-1:0][XWDT-1:0]   rd_addr,
  output logic [NREAD-1:0][XLEN-1:0]   rd_data,
  input  logic [NWRITE-1:0]            wr_en,
  input  logic [NWRITE-1:0][XWDT-1:0]  wr_addr,
  input  logic [NWRITE-1:0][XLEN-1:0]  wr_data,
  input  logic [NWRITE-1:0][1:0]       wr_size,
  input  logic [NWRITE-1:0][2:0]       wr_pos,
  output logic [NWRITE-1:0]            wr_err
);

  localparam int NB = XLEN / 8;

  rf_state_t                state, state_d;
  logic [XWDT-1:0]          cnt, cnt_d;
  logic [XN-1:0][XLEN-1:0]  regs, nxt;

  logic [NWRITE-1:0][NB-1:0]   be;
  logic [NWRITE-1:0][XLEN-1:0] wd;
  logic [NWRITE-1:0]           ill, acc, err;

  for (genvar p = 0; p < NWRITE; p++) begin : g_wp
    rfile_wmask #(.XLEN(XLEN)) u_wm (
      .size    (wr_size[p]),
      .pos     (wr_pos[p]),
      .data    (wr_data[p]),
      .be      (be[p]),
      .wdata   (wd[p]),
      .illegal (ill[p])
    );

    // r0 discard is silent and takes precedence over the size/position check.
    logic r0_hit;
    assign r0_hit = (ZERO_R0 != 0) && (wr_addr[p] == '0);
    assign acc[p] = wr_en[p] && (state == RUN) && !ill[p] && !r0_hit;
    assign err[p] = wr_en[p] && (state == RUN) &&  ill[p] && !r0_hit;
  end

  // Byte-wise merge; later (higher-index) ports overwrite earlier ones.
  always_comb begin
    nxt = regs;
    for (int p = 0; p < NWRITE; p++)
      if (acc[p])
        for (int b = 0; b < NB; b++)
          if (be[p][b]) nxt[wr_addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
  end

  // Init sweep next-state: clear one register per edge, then run.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state == INIT) begin
      cnt_d = cnt + 1'b1;
      if (cnt == XWDT'(XN - 1)) state_d = RUN;
    end
  end

  // FSM, counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= INIT;
      cnt    <= '0;
      wr_err <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      wr_err <= err;
    end
  end

  // Storage: zeroed one entry at a time during INIT, merged writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) regs[cnt] <= '0;
      else               regs      <= nxt;
    end
  end

  assign ready = (state == RUN);

  // Combinational reads; zero during INIT and for hardwired r0.
  always_comb begin
    for (int r = 0; r < NREAD; r++) begin
      rd_data[r] = '0;
      if (state == RUN && !((ZERO_R0 != 0) && rd_addr[r] == '0))
        rd_data[r] = (BYPASS != 0) ? nxt[rd_addr[r]] : regs[rd_addr[r]];
    end
  end

endmodule

// File: tb/tb_rfile_mp.sv
// Randomized + directed bench for rfile_mp; one bypass and one non-bypass
// instance share the same stimulus and a byte-level reference model.
module tb_rfile_mp;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0][5:0]      rd_addr;
  logic [2:0][63:0]     rd_data_b, rd_data_n;
  logic [1:0]           wr_en;
  logic [1:0][5:0]      wr_addr;
  logic [1:0][63:0]     wr_data;
  logic [1:0][1:0]      wr_size;
  logic [1:0][2:0]      wr_pos;
  logic [1:0]           wr_err_b, wr_err_n;
  logic                 ready_b, ready_n;

  always #5 clk = ~clk;

  rfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .wr_pos(wr_pos), .wr_err(wr_err_b)
  );

  rfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ready(ready_n),
    .rd_addr(rd_addr), .rd_data(rd_data_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .wr_pos(wr_pos), .wr_err(wr_err_n)
  );

  // Reference model
  logic [63:0] mem     [64];
  logic [63:0] nxt_mem [64];
  logic [1:0]  m_err, nxt_err;
  logic        m_ready;
  int          m_cnt;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Post-edge contents implied by the current write inputs.
  task automatic compute_next();
    int sb, off;
    logic [63:0] lowm;
    for (int i = 0; i < 64; i++) nxt_mem[i] = mem[i];
    nxt_err = '0;
    for (int p = 0; p < 2; p++) begin
      if (m_ready && wr_en[p] && wr_addr[p] != 0) begin
        sb  = 1 << wr_size[p];
        off = (wr_size[p] == 2'd3) ? 0 : int'(wr_pos[p]) * sb;
        if (off + sb > 8) nxt_err[p] = 1'b1;
        else begin
          lowm = (sb == 8) ? '1 : ((64'd1 << (8*sb)) - 64'd1);
          nxt_mem[wr_addr[p]] = (nxt_mem[wr_addr[p]] & ~(lowm << (8*off)))
                              | ((wr_data[p] & lowm) << (8*off));
        end
      end
    end
  endtask

  task automatic check_reads(input string tag);
    logic [63:0] eb, en;
    #1;
    compute_next();
    for (int r = 0; r < 3; r++) begin
      eb = (!m_ready || rd_addr[r] == 0) ? 64'd0 : nxt_mem[rd_addr[r]];
      en = (!m_ready || rd_addr[r] == 0) ? 64'd0 : mem[rd_addr[r]];
      chk({tag, "_byp"}, rd_data_b[r], eb);
      chk({tag, "_nob"}, rd_data_n[r], en);
    end
  endtask

  // One clock edge applied to both the model and the DUTs.
  task automatic tick();
    compute_next();
    @(posedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_ready = 1'b0; m_err = '0;
    end else if (!m_ready) begin
      mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 64) m_ready = 1'b1;
      m_err = '0;
    end else begin
      for (int i = 0; i < 64; i++) mem[i] = nxt_mem[i];
      m_err = nxt_err;
    end
    #1;
    chk("ready_b", {63'd0, ready_b}, {63'd0, m_ready});
    chk("ready_n", {63'd0, ready_n}, {63'd0, m_ready});
    chk("err_b", {62'd0, wr_err_b}, {62'd0, m_err});
    chk("err_n", {62'd0, wr_err_n}, {62'd0, m_err});
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_size = '0; wr_pos = '0;
  endtask

  task automatic wr(input int p, input logic [5:0] a, input logic [63:0] d,
                    input logic [1:0] s, input logic [2:0] ps);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d; wr_size[p] = s; wr_pos[p] = ps;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    m_ready = 1'b0; m_cnt = 0; m_err = '0;
    idle();
    rd_addr = '0;
    rst_n = 1'b0;
    tick(); tick();
    rd_addr = {6'd5, 6'd1, 6'd63};
    check_reads("reset_rd");

    // INIT sweep: ready exactly 64 edges after release, reads zero meanwhile.
    rst_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      rd_addr = {6'($urandom), 6'($urandom), 6'($urandom)};
      wr(0, 6'd4, 64'hFFFF, 2'd3, 3'd0);
      check_reads("init_rd");
      tick();
    end
    idle();
    chk("ready_after_init", {63'd0, ready_b}, 64'd1);
    rd_addr = {6'd4, 6'd2, 6'd63};
    check_reads("post_init_rd");
    chk("init_zero_r4", rd_data_n[2], 64'd0);

    // Double then byte at pos 3 into r5.
    wr(0, 6'd5, 64'hDEADBEEF_CAFEF00D, 2'd3, 3'd0);
    tick();
    idle();
    wr(1, 6'd5, 64'h11, 2'd0, 3'd3);
    tick();
    idle();
    rd_addr = {6'd5, 6'd5, 6'd5};
    check_reads("r5");
    chk("r5_const", rd_data_n[0], 64'hDEADBEEF_11FEF00D);

    // Same-cycle conflict on r7 with a known old value.
    wr(0, 6'd7, 64'h12345678_9ABCDEF0, 2'd3, 3'd0);
    tick();
    idle();
    wr(0, 6'd7, 64'd0, 2'd3, 3'd0);
    wr(1, 6'd7, 64'hABCD, 2'd1, 3'd1);
    rd_addr = {6'd7, 6'd7, 6'd7};
    check_reads("r7_same");
    chk("r7_byp_const", rd_data_b[0], 64'h00000000_ABCD0000);
    chk("r7_old_const", rd_data_n[0], 64'h12345678_9ABCDEF0);
    tick();
    idle();
    check_reads("r7_after");
    chk("r7_nob_const", rd_data_n[1], 64'h00000000_ABCD0000);

    // Illegal word at pos 2: error pulse, register untouched.
    wr(0, 6'd9, 64'hFFFF_FFFF, 2'd2, 3'd2);
    tick();
    chk("illegal_err", {62'd0, wr_err_b}, 64'd1);
    idle();
    rd_addr = {6'd9, 6'd9, 6'd9};
    check_reads("illegal_rd");
    chk("illegal_r9", rd_data_n[0], 64'd0);
    tick();
    chk("err_one_cycle", {62'd0, wr_err_b}, 64'd0);

    // r0 is hardwired: no data, no error.
    wr(1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 3'd0);
    rd_addr = {6'd0, 6'd0, 6'd0};
    check_reads("r0_same");
    tick();
    idle();
    chk("r0_no_err", {62'd0, wr_err_b}, 64'd0);
    check_reads("r0_after");

    // Randomized traffic over a small address window to force conflicts.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        wr(p, 6'($urandom_range(0, 7)), {$urandom, $urandom},
           2'($urandom), 3'($urandom));
      wr_en   = 2'($urandom);
      rd_addr = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom)};
      check_reads("rand");
      tick();
    end
    idle();

    // Reset at cycle 20 of INIT.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    rst_n = 1'b0; tick();
    chk("midinit_ready", {63'd0, ready_b}, 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 63; c++) tick();
    chk("midinit_63", {63'd0, ready_b}, 64'd0);
    tick();
    chk("midinit_64", {63'd0, ready_b}, 64'd1);

    // Reset in RUN after writing r3; the write at the reset edge is lost.
    wr(0, 6'd3, 64'hA5A5_A5A5_5A5A_5A5A, 2'd3, 3'd0);
    tick();
    wr(0, 6'd3, 64'h1234, 2'd3, 3'd0);
    rst_n = 1'b0;
    tick();
    idle();
    chk("run_rst_ready", {63'd0, ready_b}, 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 64; c++) tick();
    chk("run_rst_ready64", {63'd0, ready_b}, 64'd1);
    rd_addr = {6'd3, 6'd3, 6'd3};
    check_reads("r3_cleared");
    chk("r3_zero", rd_data_n[0], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
